// File: rtl/r2sdf_bf_stage_if.sv
// rtl/r2sdf_bf_stage_if.sv - sample stream and twiddle-index bundle for one R2SDF butterfly stage
interface r2sdf_bf_stage_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = IN_W + 1,
    parameter int IDX_W = 2
);
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_r;
    logic signed [IN_W-1:0]  in_i;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_r;
    logic signed [OUT_W-1:0] out_i;
    logic                    tw_en;
    logic [IDX_W-1:0]        tw_idx;

    modport master (
        output in_valid, in_r, in_i,
        input  out_valid, out_r, out_i, tw_en, tw_idx
    );

    modport slave (
        input  in_valid, in_r, in_i,
        output out_valid, out_r, out_i, tw_en, tw_idx
    );
endinterface

// File: rtl/r2sdf_bf_stage.sv
// rtl/r2sdf_bf_stage.sv - radix-2 SDF DIF butterfly stage with feedback delay line and twiddle-index sequencer
module r2sdf_bf_stage #(
    parameter int IN_W  = 8,
    parameter int OUT_W = IN_W + 1,
    parameter int DELAY = 4,
    parameter int IDX_W = (DELAY > 1) ? $clog2(DELAY) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    r2sdf_bf_stage_if.slave  bus
);
    localparam int CW = $clog2(2 * DELAY);

    logic [CW-1:0]           cnt;
    logic                    primed;
    logic signed [OUT_W-1:0] dl_r [DELAY];
    logic signed [OUT_W-1:0] dl_i [DELAY];

    logic                    phase;
    logic [IDX_W-1:0]        n;
    logic signed [OUT_W-1:0] b_r;
    logic signed [OUT_W-1:0] b_i;
    logic signed [OUT_W-1:0] a_r;
    logic signed [OUT_W-1:0] a_i;

    always_comb begin
        phase = cnt[CW-1];
        n     = IDX_W'(cnt & CW'(DELAY - 1));
        b_r   = {{(OUT_W - IN_W){bus.in_r[IN_W-1]}}, bus.in_r};
        b_i   = {{(OUT_W - IN_W){bus.in_i[IN_W-1]}}, bus.in_i};
        a_r   = dl_r[0];
        a_i   = dl_i[0];
    end

    // Phase 0 fills the line with raw samples while draining last span's
    // differences; phase 1 emits sums and refills the line with differences.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt           <= '0;
            primed        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_r     <= '0;
            bus.out_i     <= '0;
            bus.tw_en     <= 1'b0;
            bus.tw_idx    <= '0;
            for (int i = 0; i < DELAY; i++) begin
                dl_r[i] <= '0;
                dl_i[i] <= '0;
            end
        end else begin
            bus.out_valid <= bus.in_valid & primed;
            if (bus.in_valid) begin
                cnt <= cnt + CW'(1);
                if (cnt == CW'(DELAY - 1)) begin
                    primed <= 1'b1;
                end
                for (int i = 0; i < DELAY - 1; i++) begin
                    dl_r[i] <= dl_r[i+1];
                    dl_i[i] <= dl_i[i+1];
                end
                if (!phase) begin
                    dl_r[DELAY-1] <= b_r;
                    dl_i[DELAY-1] <= b_i;
                    bus.out_r     <= a_r;
                    bus.out_i     <= a_i;
                    bus.tw_en     <= 1'b1;
                    bus.tw_idx    <= n;
                end else begin
                    dl_r[DELAY-1] <= a_r - b_r;
                    dl_i[DELAY-1] <= a_i - b_i;
                    bus.out_r     <= a_r + b_r;
                    bus.out_i     <= a_i + b_i;
                    bus.tw_en     <= 1'b0;
                    bus.tw_idx    <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_r2sdf_bf_stage.sv
// tb/tb_r2sdf_bf_stage.sv - scoreboard bench for r2sdf_bf_stage (D=4 and D=1 instances)
module tb_r2sdf_bf_stage;
    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    r2sdf_bf_stage_if #(.IN_W(8), .OUT_W(9), .IDX_W(2)) b4 ();
    r2sdf_bf_stage_if #(.IN_W(8), .OUT_W(9), .IDX_W(1)) b1 ();

    r2sdf_bf_stage #(.IN_W(8), .OUT_W(9), .DELAY(4), .IDX_W(2)) dut4 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b4)
    );

    r2sdf_bf_stage #(.IN_W(8), .OUT_W(9), .DELAY(1), .IDX_W(1)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b1)
    );

    typedef struct {
        int r;
        int i;
        int en;
        int idx;
    } exp_t;

    exp_t sb [$];
    int   hr [$];
    int   hi [$];
    int   k;
    int   errors = 0;
    int   checks = 0;
    int   last_r;
    int   last_i;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: within each 2D span, the second half yields x[n]+x[n+D] and
    // the next span's first half yields x[n]-x[n+D] with twiddle index n.
    task automatic step(input bit v, input int r, input int i);
        bit   exp_v;
        exp_t e;
        int   n;
        b4.in_valid = v;
        b4.in_r     = 8'(r);
        b4.in_i     = 8'(i);
        exp_v       = 1'b0;
        if (v) begin
            hr.push_back(r);
            hi.push_back(i);
            n = k % 4;
            if ((k % 8) >= 4) begin
                e = '{hr[k-4] + r, hi[k-4] + i, 0, 0};
                sb.push_back(e);
                exp_v = 1'b1;
            end else if (k >= 8) begin
                e = '{hr[k-8] - hr[k-4], hi[k-8] - hi[k-4], 1, n};
                sb.push_back(e);
                exp_v = 1'b1;
            end
            k++;
        end
        @(posedge clk);
        #1;
        b4.in_valid = 1'b0;
        check("out_valid", b4.out_valid, exp_v);
        if (b4.out_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_r", b4.out_r, e.r);
                check("out_i", b4.out_i, e.i);
                check("tw_en", b4.tw_en, e.en);
                check("tw_idx", b4.tw_idx, e.idx);
            end
        end else if (!v) begin
            check("hold_r", b4.out_r, last_r);
            check("hold_i", b4.out_i, last_i);
        end
        last_r = b4.out_r;
        last_i = b4.out_i;
    endtask

    task automatic do_reset(input bit v);
        rstn        = 1'b0;
        b4.in_valid = v;
        b4.in_r     = 8'sd77;
        b4.in_i     = 8'sd33;
        @(posedge clk);
        #1;
        rstn        = 1'b1;
        b4.in_valid = 1'b0;
        check("rst_valid", b4.out_valid, 0);
        check("rst_r", b4.out_r, 0);
        check("rst_i", b4.out_i, 0);
        check("rst_tw_en", b4.tw_en, 0);
        check("rst_tw_idx", b4.tw_idx, 0);
        check("rst_sb_empty", sb.size(), 0);
        sb.delete();
        hr.delete();
        hi.delete();
        k      = 0;
        last_r = 0;
        last_i = 0;
    endtask

    task automatic step1(input bit v, input int r);
        b1.in_valid = v;
        b1.in_r     = 8'(r);
        b1.in_i     = 8'sd0;
        @(posedge clk);
        #1;
        b1.in_valid = 1'b0;
    endtask

    initial begin
        rstn        = 1'b0;
        b4.in_valid = 1'b0;
        b4.in_r     = '0;
        b4.in_i     = '0;
        b1.in_valid = 1'b0;
        b1.in_r     = '0;
        b1.in_i     = '0;
        k           = 0;
        @(posedge clk);
        do_reset(1'b0);
        check("rst_d1_valid", b1.out_valid, 0);
        check("rst_d1_r", b1.out_r, 0);

        // basic span: 1..8 then flush
        for (int j = 1; j <= 8; j++) step(1'b1, j, 0);
        for (int j = 0; j < 4; j++) step(1'b1, 0, 0);
        do_reset(1'b0);

        // gapped: same data, idle cycle after every sample
        for (int j = 1; j <= 8; j++) begin
            step(1'b1, j, 0);
            step(1'b0, 0, 0);
        end
        for (int j = 0; j < 4; j++) begin
            step(1'b1, 0, 0);
            step(1'b0, 0, 0);
        end
        do_reset(1'b0);

        // extremes: a=(-128,127), b=(-128,-128)
        for (int j = 0; j < 4; j++) step(1'b1, -128, 127);
        for (int j = 0; j < 4; j++) step(1'b1, -128, -128);
        for (int j = 0; j < 4; j++) step(1'b1, 0, 0);
        do_reset(1'b0);

        // three back-to-back random spans then flush
        for (int j = 0; j < 24; j++) begin
            step(1'b1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        end
        for (int j = 0; j < 4; j++) step(1'b1, 0, 0);
        do_reset(1'b0);

        // reset mid-span with in_valid high; next input starts a fresh stream
        for (int j = 0; j < 6; j++) step(1'b1, 10 + j, -j);
        do_reset(1'b1);
        for (int j = 0; j < 8; j++) step(1'b1, 3 * j - 9, j + 1);
        for (int j = 0; j < 4; j++) step(1'b1, 0, 0);
        check("final_sb_empty", sb.size(), 0);

        // D=1 corner: 3,5,0 -> 8 (bypass), -2 (twiddle 0)
        step1(1'b1, 3);
        check("d1_first_valid", b1.out_valid, 0);
        step1(1'b1, 5);
        check("d1_sum_valid", b1.out_valid, 1);
        check("d1_sum_r", b1.out_r, 8);
        check("d1_sum_tw_en", b1.tw_en, 0);
        step1(1'b1, 0);
        check("d1_diff_valid", b1.out_valid, 1);
        check("d1_diff_r", b1.out_r, -2);
        check("d1_diff_i", b1.out_i, 0);
        check("d1_diff_tw_en", b1.tw_en, 1);
        check("d1_diff_tw_idx", b1.tw_idx, 0);
        step1(1'b0, 0);
        check("d1_gap_valid", b1.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
